cpu_lsu: RTL and testbench
==========================

# cpu_lsu

Load/store unit placed directly downstream of the execute stage. It takes the effective address computed by the ALU, plus store data and access attributes, and runs one data-bus transaction per request through a req/ack handshake. Stores get byte-lane steering; load results are extracted from the addressed lane and sign- or zero-extended. While it is busy it stalls the pipeline, and it also handles flushes, misaligned accesses and an optional bus timeout.

## Interface
- BUS_TIMEOUT, 255: cycles `dbus_req` may stay high unacknowledged before a fault (used only with the timeout feature).
- clk  in  1  core clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_flag  in  1  pipeline flush; aborts the pending or accepted request.
- lsu_en  in  1  single-cycle request strobe.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- lsu_unsigned  in  1  zero-extend load result (LBU/LHU).
- addr  in  32  effective address, taken from the execute result.
- wdata  in  32  store data (rs2).
- lsu_busy  out  1  high whenever the state is not IDLE; used as pipeline stall.
- lsu_done  out  1  one-cycle pulse on successful completion of a load or store.
- rdata  out  32  load result; holds its value until the next load completes.
- rdata_vld  out  1  one-cycle pulse, loads only, coincident with `lsu_done`.
- misalign  out  1  one-cycle pulse on a misaligned or illegal-size request.
- fault  out  1  one-cycle pulse on bus timeout.
- dbus_req, dbus_we  out  1  bus request and direction.
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dbus_wdata  out  32  lane-replicated store data.
- dbus_be  out  4  byte enables (all zero for loads).
- dbus_ack  in  1  bus acknowledge; `dbus_rdata` is valid in the same cycle.
- dbus_rdata  in  32  bus read word.

## Operation
- States: IDLE, REQ, DRAIN.
- IDLE, `lsu_en` set and `flush_flag` clear:
  - If the access is aligned: latch the attributes, drive the bus outputs, go to REQ.
  - If the access is misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size 11): pulse `misalign` next cycle, stay in IDLE, no bus activity.
- REQ: `dbus_req`=1 and all `dbus_*` outputs held stable. When `dbus_ack`=1 is sampled, go to IDLE next cycle and pulse `lsu_done`. For a load, also update `rdata` and pulse `rdata_vld`.
- `flush_flag` while in REQ with no ack that cycle: go to DRAIN. DRAIN keeps `dbus_req` asserted until ack, discards the result, and produces no done/vld/rdata update.
- `flush_flag` in the same cycle as an ack in REQ: the transaction counts as finished and is discarded. Return to IDLE with no done pulse.
- `lsu_en` together with `flush_flag` in IDLE: the request is ignored.
- `lsu_en` while `lsu_busy`=1: ignored.
- Store steering, with o = addr[1:0]:
  - byte: wdata = {4{wdata[7:0]}}, be = 4'b0001<<o.
  - half: wdata = {2{wdata[15:0]}}, be = 4'b0011<<o.
  - word: wdata passed through, be = 4'b1111.
- Load extraction: byte = dbus_rdata[8o+7:8o]; half = dbus_rdata[8o+15:8o]. Sign-extend from the top bit of the lane unless `lsu_unsigned`=1.

## Timing
- Reset (rst=1 at an edge) applies regardless of state, including mid-transaction (the bus master must tolerate the dropped req). Next cycle:
  - state IDLE.
  - `dbus_req`, `dbus_we`, `lsu_busy`, `lsu_done`, `rdata_vld`, `misalign`, `fault` = 0.
  - `rdata`, `dbus_addr`, `dbus_wdata` = 0; `dbus_be` = 0.
- Request strobed at edge N: `dbus_req`=1 and `lsu_busy`=1 during cycle N+1.
- Ack sampled at edge N+1+k: `dbus_req`=0, `lsu_busy`=0, `lsu_done`=1 (and `rdata_vld`=1 for loads) during cycle N+2+k.
- Minimum latency (k=0) is 2 cycles.
- Back-to-back: the earliest new `lsu_en` accepted is at the edge ending the done cycle.
- Misaligned request: `misalign`=1 during cycle N+1; `lsu_busy` stays 0.

## Configuration
- `CPU_LSU_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter counts cycles in REQ/DRAIN. It clears on entry to those states.
  - When the count reaches BUS_TIMEOUT without ack: drop `dbus_req` and return to IDLE. Pulse `fault` only if the timeout happened in REQ; a DRAIN timeout is silent.
- Undefined: no counter, `fault` tied 0, and the unit waits for ack indefinitely.

## Test plan
- Word load, addr=0x100, ack after 3 cycles, dbus_rdata=0xDEADBEEF -> dbus_addr=0x100, rdata=0xDEADBEEF with rdata_vld 1 cycle, busy for 4 cycles.
- Byte store, addr=0x103, wdata=0x000000A5 -> dbus_be=4'b1000, dbus_wdata=0xA5A5A5A5, lsu_done pulse, rdata_vld=0.
- LH at 0x102 with rdata=0x8001_0000 -> rdata=0xFFFF8001; LHU with the same data -> 0x00008001.
- Word load at addr=0x102 -> misalign pulse at N+1, dbus_req never rises, busy stays 0.
- flush_flag asserted 1 cycle after req, ack 2 cycles later -> req held through DRAIN until ack, then drops; no lsu_done or rdata_vld, rdata unchanged.
- With CPU_LSU_TIMEOUT_EN and BUS_TIMEOUT=4, ack never given -> req drops after 4 cycles, fault pulses once, next load completes normally.

Source files
------------

// File: rtl/cpu_lsu_if.sv
// Data-bus bundle between the load/store unit and the memory side.
// The LSU drives the request half; the memory returns ack and read data.
interface cpu_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/cpu_lsu.sv
// Load/store unit: one req/ack bus transaction per request, lane steering,
// load extension, flush drain. CPU_LSU_TIMEOUT_EN adds a bus timeout.
module cpu_lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_flag,
    input  logic        lsu_en,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] rdata,
    output logic        rdata_vld,
    output logic        misalign,
    output logic        fault,
    cpu_lsu_if.master   dbus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        vld_q;
    logic        mis_q;
    logic        fault_q;

    logic        mis_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_d;
    logic        tmo;

    always_comb begin
        unique case (lsu_size)
            2'b00:   mis_d = 1'b0;
            2'b01:   mis_d = addr[0];
            2'b10:   mis_d = |addr[1:0];
            default: mis_d = 1'b1;
        endcase
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        unique case (lsu_size)
            2'b00: begin
                wdata_d = {4{wdata[7:0]}};
                be_d    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_d = {2{wdata[15:0]}};
                be_d    = 4'b0011 << addr[1:0];
            end
            default: begin
                wdata_d = wdata;
                be_d    = 4'b1111;
            end
        endcase
        if (!lsu_we) begin
            be_d = 4'b0000;
        end
    end

    // Half accesses are aligned, so only off_q[1] selects the lane.
    always_comb begin
        ld_b = dbus.rdata[{off_q, 3'b000} +: 8];
        ld_h = dbus.rdata[{off_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'b00:   ld_d = {{24{~uns_q & ld_b[7]}}, ld_b};
            2'b01:   ld_d = {{16{~uns_q & ld_h[15]}}, ld_h};
            default: ld_d = dbus.rdata;
        endcase
    end

`ifdef CPU_LSU_TIMEOUT_EN
    localparam int CW = (BUS_TIMEOUT > 255) ? $clog2(BUS_TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt_q;
    logic          enter;

    assign enter = ((state_q == IDLE) && lsu_en && !flush_flag && !mis_d)
                || ((state_q == REQ) && !dbus.ack && !tmo && flush_flag);
    assign tmo   = (state_q != IDLE) && (cnt_q == CW'(BUS_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || enter) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (lsu_en && !flush_flag) begin
                        if (mis_d) begin
                            mis_q <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= lsu_we;
                            addr_q  <= {addr[31:2], 2'b00};
                            wdata_q <= wdata_d;
                            be_q    <= be_d;
                            size_q  <= lsu_size;
                            uns_q   <= lsu_unsigned;
                            off_q   <= addr[1:0];
                        end
                    end
                end
                REQ: begin
                    if (dbus.ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        // A flush in the ack cycle retires the access silently.
                        if (!flush_flag) begin
                            done_q <= 1'b1;
                            if (!we_q) begin
                                rdata_q <= ld_d;
                                vld_q   <= 1'b1;
                            end
                        end
                    end else if (tmo) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                    end else if (flush_flag) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dbus.ack || tmo) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_busy   = (state_q != IDLE);
    assign lsu_done   = done_q;
    assign rdata      = rdata_q;
    assign rdata_vld  = vld_q;
    assign misalign   = mis_q;
    assign fault      = fault_q;

    assign dbus.req   = req_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.wdata = wdata_q;
    assign dbus.be    = be_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Self-checking bench for cpu_lsu: directed cases plus randomized accesses
// checked against an arithmetic model of steering and load extension.
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_flag;
    logic        lsu_en;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] rdata;
    logic        rdata_vld;
    logic        misalign;
    logic        fault;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_rdata;

`ifdef CPU_LSU_TIMEOUT_EN
    localparam int MAXD = 2;
`else
    localparam int MAXD = 5;
`endif

    always #5 clk = ~clk;

    cpu_lsu_if dbus ();

    cpu_lsu #(.BUS_TIMEOUT(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush_flag   (flush_flag),
        .lsu_en       (lsu_en),
        .lsu_we       (lsu_we),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .lsu_busy     (lsu_busy),
        .lsu_done     (lsu_done),
        .rdata        (rdata),
        .rdata_vld    (rdata_vld),
        .misalign     (misalign),
        .fault        (fault),
        .dbus         (dbus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [1:0] sz, input logic [1:0] o);
        if (sz == 2'd3) return 1'b1;
        return (int'(o) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [1:0] sz,
                                        input logic [1:0] o);
        int v;
        if (!we) return 4'b0000;
        v = ((1 << nbytes(sz)) - 1) << int'(o);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz,
                                         input logic [31:0] w);
        if (sz == 2'd0) return {24'd0, w[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'd0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] o,
                                           input logic [31:0] w);
        int          bits;
        logic [31:0] mask;
        logic [31:0] v;
        bits = 8 * nbytes(sz);
        if (bits == 32) return w;
        mask = (32'd1 << bits) - 32'd1;
        v    = (w >> (8 * int'(o))) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd,
                       input int fl, input bit poke);
        bit fin;
        lsu_en       = 1'b1;
        lsu_we       = we;
        lsu_size     = sz;
        lsu_unsigned = uns;
        addr         = a;
        wdata        = wd;
        @(negedge clk);
        lsu_en = 1'b0;
        addr   = $urandom;
        wdata  = $urandom;
        if (m_mis(sz, a[1:0])) begin
            chk("mis_pulse", misalign, 1);
            chk("mis_busy", lsu_busy, 0);
            chk("mis_req", dbus.req, 0);
            @(negedge clk);
            chk("mis_one_cycle", misalign, 0);
            chk("mis_req_after", dbus.req, 0);
            chk("mis_busy_after", lsu_busy, 0);
            return;
        end
        for (int k = 0; k <= dly; k++) begin
            chk("req", dbus.req, 1);
            chk("busy", lsu_busy, 1);
            chk("no_early_done", lsu_done, 0);
            chk("bus_addr", dbus.addr, {a[31:2], 2'b00});
            chk("bus_we", dbus.we, we);
            chk("bus_be", dbus.be, m_be(we, sz, a[1:0]));
            if (we) chk("bus_wdata", dbus.wdata, m_wd(sz, wd));
            lsu_en       = poke && (k == 0);
            lsu_we       = 1'($urandom);
            lsu_size     = 2'($urandom);
            addr         = $urandom;
            dbus.ack     = (k == dly);
            dbus.rdata   = (k == dly) ? rd : $urandom;
            flush_flag   = (k == fl);
            @(negedge clk);
            lsu_en     = 1'b0;
            dbus.ack   = 1'b0;
            flush_flag = 1'b0;
        end
        fin = (fl < 0) || (fl > dly);
        if (fin && !we) exp_rdata = m_load(sz, uns, a[1:0], rd);
        chk("req_drop", dbus.req, 0);
        chk("busy_drop", lsu_busy, 0);
        chk("done", lsu_done, fin);
        chk("rdata_vld", rdata_vld, fin && !we);
        chk("rdata", rdata, exp_rdata);
        chk("fault_quiet", fault, 0);
        @(negedge clk);
        chk("done_one_cycle", lsu_done, 0);
        chk("vld_one_cycle", rdata_vld, 0);
    endtask

    initial begin
        logic [1:0] sz;
        int         dly;
        int         fl;
        rst          = 1'b1;
        flush_flag   = 1'b0;
        lsu_en       = 1'b0;
        lsu_we       = 1'b0;
        lsu_size     = 2'b00;
        lsu_unsigned = 1'b0;
        addr         = '0;
        wdata        = '0;
        dbus.ack     = 1'b0;
        dbus.rdata   = '0;
        exp_rdata    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", dbus.req, 0);
        chk("rst_we", dbus.we, 0);
        chk("rst_busy", lsu_busy, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_vld", rdata_vld, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", dbus.addr, 0);
        chk("rst_wdata", dbus.wdata, 0);
        chk("rst_be", dbus.be, 0);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, -1, 1'b0);
        chk("lw_value", rdata, 32'hDEAD_BEEF);
        txn(1'b1, 2'd0, 1'b0, 32'h103, 32'hA5, 0, 32'h0, -1, 1'b0);
        txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1, 32'h8001_0000, -1, 1'b0);
        chk("lh_value", rdata, 32'hFFFF_8001);
        txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, 32'h8001_0000, -1, 1'b0);
        chk("lhu_value", rdata, 32'h0000_8001);
        txn(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, 32'h0000_9C00, -1, 1'b1);
        chk("lb_value", rdata, 32'hFFFF_FF9C);
        txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 32'h0, -1, 1'b0);
        txn(1'b0, 2'd3, 1'b0, 32'h104, 32'h0, 0, 32'h0, -1, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 3, 32'h1234_5678, 1, 1'b0);
        chk("flush_keeps_rdata", rdata, 32'h0000_0080 ^ 32'hFFFF_FF1C);
        txn(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 2, 32'h5555_5555, 2, 1'b0);
        txn(1'b1, 2'd1, 1'b0, 32'h20A, 32'hBEEF, 1, 32'h0, -1, 1'b1);
`ifndef CPU_LSU_TIMEOUT_EN
        txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 20, 32'hCAFE_F00D, -1, 1'b0);
`endif

        lsu_en     = 1'b1;
        flush_flag = 1'b1;
        lsu_we     = 1'b0;
        lsu_size   = 2'd2;
        addr       = 32'h400;
        @(negedge clk);
        lsu_size = 2'd3;
        @(negedge clk);
        lsu_en     = 1'b0;
        flush_flag = 1'b0;
        chk("flush_ignore_req", dbus.req, 0);
        chk("flush_ignore_busy", lsu_busy, 0);
        chk("flush_ignore_mis", misalign, 0);

        for (int i = 0; i < 60; i++) begin
            sz  = 2'($urandom);
            dly = $urandom_range(0, MAXD);
            fl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, dly) : -1;
            txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom,
                dly, $urandom, fl, 1'($urandom));
        end

        lsu_en   = 1'b1;
        lsu_we   = 1'b0;
        lsu_size = 2'd2;
        addr     = 32'h500;
        @(negedge clk);
        lsu_en = 1'b0;
        chk("pre_rst_req", dbus.req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        exp_rdata = '0;
        chk("midrst_req", dbus.req, 0);
        chk("midrst_busy", lsu_busy, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_addr", dbus.addr, 0);
        chk("midrst_be", dbus.be, 0);
        @(negedge clk);
        chk("midrst_idle", lsu_busy, 0);

`ifdef CPU_LSU_TIMEOUT_EN
        lsu_en   = 1'b1;
        lsu_we   = 1'b0;
        lsu_size = 2'd2;
        addr     = 32'h600;
        @(negedge clk);
        lsu_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("tmo_req", dbus.req, 1);
            chk("tmo_no_fault", fault, 0);
            @(negedge clk);
        end
        chk("tmo_req_drop", dbus.req, 0);
        chk("tmo_fault", fault, 1);
        chk("tmo_busy", lsu_busy, 0);
        chk("tmo_no_done", lsu_done, 0);
        @(negedge clk);
        chk("tmo_fault_once", fault, 0);
        txn(1'b0, 2'd2, 1'b0, 32'h604, 32'h0, 1, 32'h0BAD_F00D, -1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
